// File: rtl/spi_reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg: shared definitions for the SPI register bank.
//   - spi_state_t : frame FSM state encoding (IDLE, ADDR, DATA, DONE)
//   - SPI_RW_*    : value of the RW bit that opens every frame
//   - frame_len() : total frame length for a given address/data width
//   - FRAME_LEN   : frame length of the default 7-bit address / 8-bit data bank
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_state_t;

    localparam logic SPI_RW_WRITE = 1'b1;
    localparam logic SPI_RW_READ  = 1'b0;

    // One RW bit, then the address field, then the data field.
    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    localparam int FRAME_LEN = frame_len(7, 8);

endpackage

// File: rtl/spi_reg_bank_if.sv
// -----------------------------------------------------------------------------
// spi_reg_bank_if: the four-wire SPI pin bundle plus the CIPO output enable.
//   spi_ncs      chip select, active low (controller -> peripheral)
//   spi_sclk     SPI clock, idles low      (controller -> peripheral)
//   spi_copi     controller-out data       (controller -> peripheral)
//   spi_cipo     peripheral-out data       (peripheral -> controller)
//   spi_cipo_oe  pad enable for spi_cipo   (peripheral -> pad logic)
// Modports: master = controller side, slave = peripheral side.
// -----------------------------------------------------------------------------
interface spi_reg_bank_if;

    logic spi_ncs;
    logic spi_sclk;
    logic spi_copi;
    logic spi_cipo;
    logic spi_cipo_oe;

    modport master (
        output spi_ncs,
        output spi_sclk,
        output spi_copi,
        input  spi_cipo,
        input  spi_cipo_oe
    );

    modport slave (
        input  spi_ncs,
        input  spi_sclk,
        input  spi_copi,
        output spi_cipo,
        output spi_cipo_oe
    );

endinterface

// File: rtl/spi_reg_bank_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge: multi-flop synchroniser for one asynchronous input, with a
// history flop for edge detection.
//   clk, rst  system clock, asynchronous active-high reset
//   i_async   asynchronous input
//   o_level   synchronised level
//   o_rise    one-clk pulse on a synchronised 0->1 transition
//   o_fall    one-clk pulse on a synchronised 1->0 transition
// RESET_VAL is the idle level of the line, so leaving reset never fabricates
// an edge from the reset pattern itself.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_hist;

    // Synchroniser chain plus one history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_hist <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_hist <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_hist;
    assign o_fall  = ~r_sync[STAGES-1] & r_hist;

endmodule

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank: SPI mode-0 peripheral giving read/write access to NUM_REGS
// registers of DATA_W bits.
// Frame (MSB first): RW (1 = write) | ADDR_W address bits | DATA_W data bits.
//   clk, rst       system clock, asynchronous active-high reset
//   spi            SPI pins (slave modport of spi_reg_bank_if)
//   regs_out       flattened registers, reg i at [i*DATA_W +: DATA_W]
//   reg_wr_strobe  one-clk pulse on the register just written
//   frame_err      one-clk pulse when a frame ends with the wrong bit count
// SCLK must be fclk/8 or slower.
// -----------------------------------------------------------------------------
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic [NUM_REGS-1:0]        reg_wr_strobe,
    output logic                       frame_err
);

    localparam int SPI_STAGES = SYNC_STAGES;
    localparam int FLEN       = frame_len(ADDR_W, DATA_W);
    localparam int HDR_W      = 1 + ADDR_W;
    localparam int CNT_W      = $clog2(FLEN + 1);
    localparam int WARM_W     = $clog2(SPI_STAGES + 2);

    localparam logic [CNT_W-1:0]  CNT_HDR_LAST   = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0]  CNT_HDR        = CNT_W'(HDR_W);
    localparam logic [CNT_W-1:0]  CNT_FRAME_LAST = CNT_W'(FLEN - 1);
    localparam logic [WARM_W-1:0] WARM_DONE      = WARM_W'(SPI_STAGES + 1);
    localparam logic [ADDR_W:0]   NUM_REGS_A     = (ADDR_W + 1)'(NUM_REGS);

    // Synchronised SPI lines
    logic w_ncs_lvl, w_ncs_rise_raw, w_ncs_fall_raw;
    logic w_sclk_lvl, w_sclk_rise_raw, w_sclk_fall_raw;
    logic w_copi, w_copi_rise, w_copi_fall;
    logic w_unused_sync;

    // Qualified events
    logic w_ready;
    logic w_ncs_rise, w_ncs_fall, w_sclk_rise, w_sclk_fall;

    // FSM
    spi_state_t r_state, w_state_nxt;

    // Frame datapath
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [ADDR_W-1:0] r_hdr;
    logic [DATA_W-1:0] r_data;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic              r_overrun;
    logic [DATA_W-1:0] r_shadow;
    logic              r_cipo;
    logic              r_cipo_oe;
    logic [WARM_W-1:0] r_warm;

    // Header decode and read mux
    logic [HDR_W-1:0]  w_hdr_full;
    logic              w_hdr_rw;
    logic [ADDR_W-1:0] w_hdr_addr;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_addr_ok;

    // FSM decoded actions
    logic w_hdr_done, w_shift_rd, w_commit, w_err_nxt;

    // Register bank
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] r_strobe;
    logic                r_frame_err;

    spi_sync_edge #(.STAGES(SPI_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst(rst), .i_async(spi.spi_ncs),
        .o_level(w_ncs_lvl), .o_rise(w_ncs_rise_raw), .o_fall(w_ncs_fall_raw)
    );

    spi_sync_edge #(.STAGES(SPI_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(spi.spi_sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise_raw), .o_fall(w_sclk_fall_raw)
    );

    spi_sync_edge #(.STAGES(SPI_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst(rst), .i_async(spi.spi_copi),
        .o_level(w_copi), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
    );

    assign w_unused_sync = ^{w_ncs_lvl, w_sclk_lvl, w_copi_rise, w_copi_fall};

    // Hold off edge detection until the chains hold real samples; otherwise
    // ncs held low through reset would look like a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_warm <= {WARM_W{1'b0}};
        end else if (r_warm != WARM_DONE) begin
            r_warm <= r_warm + WARM_W'(1);
        end else begin
            r_warm <= r_warm;
        end
    end

    assign w_ready     = (r_warm == WARM_DONE);
    assign w_ncs_rise  = w_ready & w_ncs_rise_raw;
    assign w_ncs_fall  = w_ready & w_ncs_fall_raw;
    // An ncs edge in the same clk masks any SCLK edge.
    assign w_sclk_rise = w_ready & w_sclk_rise_raw & ~w_ncs_rise_raw & ~w_ncs_fall_raw;
    assign w_sclk_fall = w_ready & w_sclk_fall_raw & ~w_ncs_rise_raw & ~w_ncs_fall_raw;

    assign w_hdr_full = {r_hdr, w_copi};
    assign w_hdr_rw   = w_hdr_full[HDR_W-1];
    assign w_hdr_addr = w_hdr_full[ADDR_W-1:0];
    assign w_addr_ok  = ({1'b0, r_addr} < NUM_REGS_A);

    // Read mux: out-of-range addresses read as zero.
    always_comb begin
        w_rd_word = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_hdr_addr == ADDR_W'(i)) begin
                w_rd_word = r_regs[i];
            end else begin
                w_rd_word = w_rd_word;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; ncs edges override everything.
    always_comb begin
        w_state_nxt = r_state;
        if (w_ncs_rise) begin
            w_state_nxt = IDLE;
        end else if (w_ncs_fall) begin
            w_state_nxt = ADDR;
        end else begin
            case (r_state)
                IDLE: w_state_nxt = IDLE;
                ADDR: begin
                    if (w_sclk_rise && (r_bit_cnt == CNT_HDR_LAST)) begin
                        w_state_nxt = DATA;
                    end else begin
                        w_state_nxt = ADDR;
                    end
                end
                DATA: begin
                    if (w_sclk_rise && (r_bit_cnt == CNT_FRAME_LAST)) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
                DONE:    w_state_nxt = DONE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM output decode: header completion, read-shadow shift, commit, error.
    always_comb begin
        w_hdr_done = 1'b0;
        w_shift_rd = 1'b0;
        w_commit   = 1'b0;
        w_err_nxt  = 1'b0;
        case (r_state)
            IDLE: w_err_nxt = 1'b0;
            ADDR: begin
                w_hdr_done = w_sclk_rise && (r_bit_cnt == CNT_HDR_LAST);
                w_err_nxt  = w_ncs_rise;
            end
            DATA: begin
                // The first falling edge in DATA precedes the first data
                // sample, so the MSB must stay put until one data bit has
                // been clocked.
                w_shift_rd = w_sclk_fall && (r_bit_cnt > CNT_HDR);
                w_err_nxt  = w_ncs_rise;
            end
            DONE: begin
                w_commit  = w_ncs_rise && !r_overrun && (r_rw == SPI_RW_WRITE) && w_addr_ok;
                w_err_nxt = w_ncs_rise && r_overrun;
            end
            default: w_err_nxt = 1'b0;
        endcase
    end

    // Frame datapath: bit counter, shift registers, read shadow and CIPO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt <= {CNT_W{1'b0}};
            r_hdr     <= {ADDR_W{1'b0}};
            r_data    <= {DATA_W{1'b0}};
            r_rw      <= 1'b0;
            r_addr    <= {ADDR_W{1'b0}};
            r_overrun <= 1'b0;
            r_shadow  <= {DATA_W{1'b0}};
            r_cipo    <= 1'b0;
            r_cipo_oe <= 1'b0;
        end else if (w_ncs_fall) begin
            r_bit_cnt <= {CNT_W{1'b0}};
            r_hdr     <= {ADDR_W{1'b0}};
            r_data    <= {DATA_W{1'b0}};
            r_overrun <= 1'b0;
            r_shadow  <= {DATA_W{1'b0}};
            r_cipo    <= 1'b0;
            r_cipo_oe <= 1'b0;
        end else if (w_ncs_rise) begin
            r_cipo    <= 1'b0;
            r_cipo_oe <= 1'b0;
        end else if (w_sclk_rise) begin
            case (r_state)
                ADDR: begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    r_hdr     <= w_hdr_full[ADDR_W-1:0];
                    if (w_hdr_done) begin
                        r_rw   <= w_hdr_rw;
                        r_addr <= w_hdr_addr;
                        if (w_hdr_rw == SPI_RW_READ) begin
                            r_shadow  <= w_rd_word;
                            r_cipo    <= w_rd_word[DATA_W-1];
                            r_cipo_oe <= 1'b1;
                        end
                    end
                end
                DATA: begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    r_data    <= {r_data[DATA_W-2:0], w_copi};
                end
                DONE:    r_overrun <= 1'b1;
                default: r_overrun <= r_overrun;
            endcase
        end else if (w_shift_rd) begin
            r_shadow <= {r_shadow[DATA_W-2:0], 1'b0};
            r_cipo   <= r_shadow[DATA_W-2];
        end
    end

    // Register bank, write strobes and frame error, all committed on ncs rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
            r_strobe    <= {NUM_REGS{1'b0}};
            r_frame_err <= 1'b0;
        end else begin
            r_strobe    <= {NUM_REGS{1'b0}};
            r_frame_err <= w_err_nxt;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && (r_addr == ADDR_W'(i))) begin
                    r_regs[i]   <= r_data;
                    r_strobe[i] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign reg_wr_strobe   = r_strobe;
    assign frame_err       = r_frame_err;
    assign spi.spi_cipo    = r_cipo;
    assign spi.spi_cipo_oe = r_cipo_oe;

endmodule

// File: tb/tb_spi_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_spi_reg_bank: directed bench for spi_reg_bank. Two instances: the default
// 5 x 8-bit bank (dut0) and a 16 x 16-bit bank with 4-bit addresses (dut1).
// SCLK runs at fclk/10 with all pin changes aligned to clk falling edges.
// -----------------------------------------------------------------------------
module tb_spi_reg_bank;

    logic clk;
    logic rst;

    logic [39:0]  regs0;
    logic [4:0]   strb0;
    logic         ferr0;
    logic [255:0] regs1;
    logic [15:0]  strb1;
    logic         ferr1;

    int checks = 0;
    int errors = 0;

    // Pulse monitors (cumulative, sampled on the falling clk edge)
    int          sc0 = 0;
    int          ec0 = 0;
    int          sc1 = 0;
    int          ec1 = 0;
    logic [4:0]  ls0 = 5'd0;
    logic [15:0] ls1 = 16'd0;

    spi_reg_bank_if bus0 ();
    spi_reg_bank_if bus1 ();

    spi_reg_bank u_dut0 (
        .clk(clk), .rst(rst), .spi(bus0.slave),
        .regs_out(regs0), .reg_wr_strobe(strb0), .frame_err(ferr0)
    );

    spi_reg_bank #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(2)) u_dut1 (
        .clk(clk), .rst(rst), .spi(bus1.slave),
        .regs_out(regs1), .reg_wr_strobe(strb1), .frame_err(ferr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (strb0 != 5'd0) begin
            sc0 <= sc0 + 1;
            ls0 <= strb0;
        end
        if (ferr0) ec0 <= ec0 + 1;
        if (strb1 != 16'd0) begin
            sc1 <= sc1 + 1;
            ls1 <= strb1;
        end
        if (ferr1) ec1 <= ec1 + 1;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic ncs, input logic sclk, input logic copi);
        if (sel == 0) begin
            bus0.spi_ncs = ncs; bus0.spi_sclk = sclk; bus0.spi_copi = copi;
        end else begin
            bus1.spi_ncs = ncs; bus1.spi_sclk = sclk; bus1.spi_copi = copi;
        end
    endtask

    // One frame of nbits, MSB first. rx/oev collect cipo/cipo_oe as seen at
    // each SCLK rising edge. rst_at >= 0 pulses rst for one clk before that bit.
    task automatic xfer(input int sel, input logic [31:0] frame, input int nbits,
                        input int rst_at, output logic [31:0] rx, output logic [31:0] oev);
        logic b;
        rx  = 32'd0;
        oev = 32'd0;
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            b = frame[nbits-1-i];
            drive(sel, 1'b0, 1'b0, b);
            #50;
            rx  = {rx[30:0],  (sel == 0) ? bus0.spi_cipo    : bus1.spi_cipo};
            oev = {oev[30:0], (sel == 0) ? bus0.spi_cipo_oe : bus1.spi_cipo_oe};
            drive(sel, 1'b0, 1'b1, b);
            #50;
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
        #50;
        drive(sel, 1'b1, 1'b0, 1'b0);
        #100;
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] oev;
        int s0, e0, s1, e1;

        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_regs0", regs0, 40'h0);
        chk("rst_strb0", strb0, 5'h0);
        chk("rst_ferr0", ferr0, 1'b0);
        chk("rst_cipo0", bus0.spi_cipo, 1'b0);
        chk("rst_oe0", bus0.spi_cipo_oe, 1'b0);
        chk("rst_regs1", regs1, 256'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Write 0xA5 to reg 2
        s0 = sc0; e0 = ec0;
        xfer(0, 32'h82A5, 16, -1, rx, oev);
        chk("wr2_regs", regs0, 40'h00_00_A5_00_00);
        chk("wr2_strobe", ls0, 5'b00100);
        chk("wr2_one_pulse", sc0 - s0, 1);
        chk("wr2_no_err", ec0 - e0, 0);

        // Write 0x3C to reg 1, read it back
        xfer(0, 32'h813C, 16, -1, rx, oev);
        chk("wr1_regs", regs0, 40'h00_00_A5_3C_00);
        chk("wr1_strobe", ls0, 5'b00010);
        s0 = sc0;
        xfer(0, 32'h0100, 16, -1, rx, oev);
        chk("rd1_data", rx[7:0], 8'h3C);
        chk("rd1_oe", oev[15:0], 16'h00FF);
        chk("rd1_oe_after", bus0.spi_cipo_oe, 1'b0);
        chk("rd1_no_strobe", sc0 - s0, 0);
        chk("rd1_regs", regs0, 40'h00_00_A5_3C_00);
        xfer(0, 32'h0200, 16, -1, rx, oev);
        chk("rd2_data", rx[7:0], 8'hA5);

        // Out-of-range write and read
        s0 = sc0; e0 = ec0;
        xfer(0, 32'h90FF, 16, -1, rx, oev);
        chk("oor_regs", regs0, 40'h00_00_A5_3C_00);
        chk("oor_no_strobe", sc0 - s0, 0);
        chk("oor_no_err", ec0 - e0, 0);
        xfer(0, 32'h1000, 16, -1, rx, oev);
        chk("oor_rd_data", rx[7:0], 8'h00);
        chk("oor_rd_oe", oev[15:0], 16'h00FF);

        // Short frame (10 bits), then long frame (17 bits)
        s0 = sc0; e0 = ec0;
        xfer(0, 32'h83FF >> 6, 10, -1, rx, oev);
        chk("short_err", ec0 - e0, 1);
        chk("short_regs", regs0, 40'h00_00_A5_3C_00);
        e0 = ec0;
        xfer(0, 32'h1_06EF, 17, -1, rx, oev);
        chk("long_err", ec0 - e0, 1);
        chk("long_regs", regs0, 40'h00_00_A5_3C_00);
        chk("bad_no_strobe", sc0 - s0, 0);

        // Reset in the data phase of a write to reg 4, then a clean write
        s0 = sc0; e0 = ec0;
        xfer(0, 32'h8477, 16, 12, rx, oev);
        chk("rstmid_regs", regs0, 40'h0);
        chk("rstmid_no_strobe", sc0 - s0, 0);
        chk("rstmid_no_err", ec0 - e0, 0);
        xfer(0, 32'h8480, 16, -1, rx, oev);
        chk("wr4_regs", regs0, 40'h80_00_00_00_00);
        chk("wr4_strobe", ls0, 5'b10000);
        chk("wr4_one_pulse", sc0 - s0, 1);

        // Wide instance: 21-bit frames, reg 15 = 0xBEEF
        s1 = sc1; e1 = ec1;
        xfer(1, 32'h1F_BEEF, 21, -1, rx, oev);
        chk("w_regs", regs1, {16'hBEEF, 240'h0});
        chk("w_strobe", ls1, 16'h8000);
        chk("w_one_pulse", sc1 - s1, 1);
        xfer(1, 32'h0F_0000, 21, -1, rx, oev);
        chk("w_rd_data", rx[15:0], 16'hBEEF);
        chk("w_rd_oe", oev[20:0], 21'h00FFFF);
        chk("w_no_err", ec1 - e1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
Parametrised SPI mode-0 peripheral that gives the host read and write access to a bank of NUM_REGS configuration registers of DATA_W bits each. It succeeds the fixed 5×8-bit write-only peripheral. New capabilities: readback on CIPO, frame-length checking with an error pulse, per-register write strobes, and a configurable synchroniser depth. It sits between the chip pins (ui_in-derived SPI lines) and the PWM/output-enable logic, which consumes the flattened register outputs.

Parameters:
NUM_REGS, 5, number of implemented registers; valid addresses are 0..NUM_REGS-1.
DATA_W, 8, register and data-field width in bits.
ADDR_W, 7, address-field width; NUM_REGS must not exceed 2**ADDR_W.
SYNC_STAGES, 2, flops per input synchroniser; minimum 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
spi_ncs  in  1  chip select, active low, asynchronous to clk
spi_sclk  in  1  SPI clock, asynchronous to clk; idles low (mode 0)
spi_copi  in  1  controller-out data
spi_cipo  out  1  peripheral-out data
spi_cipo_oe  out  1  output enable for spi_cipo; high only while selected in a read frame
regs_out  out  NUM_REGS*DATA_W  flattened registers; register i occupies bits [i*DATA_W +: DATA_W]
reg_wr_strobe  out  NUM_REGS  one-clk pulse on the register just written
frame_err  out  1  one-clk pulse when a frame ends with the wrong bit count

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst. During reset, all synchronisers go to the idle pattern (ncs=1, sclk=0, copi=0). regs_out, reg_wr_strobe, frame_err, spi_cipo and spi_cipo_oe all reset to 0.
- Synchronisation: each SPI input passes through SPI_STAGES=SYNC_STAGES flops, plus one history flop used for edge detection. All logic uses only the synchronised versions.
- Supported SCLK frequency: fclk/8 or slower.
- Frame format: FRAME_LEN = 1 + ADDR_W + DATA_W bits, sent MSB first.
  - Bit 0 is RW: 1 = write, 0 = read.
  - Next ADDR_W bits are the address.
  - Last DATA_W bits are the data.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE → ADDR on an ncs falling edge. This clears the bit counter and the shift register.
  - ADDR: shift in COPI on each SCLK rising edge. After 1+ADDR_W bits, latch RW and the address, then move to DATA.
  - On that same transition, if RW=0: load the read shadow with register[addr], or all zeros if addr ≥ NUM_REGS. Drive the shadow MSB on spi_cipo and assert spi_cipo_oe.
  - DATA: shift in COPI on each SCLK rising edge. On each SCLK falling edge, shift the read shadow left (fill with 0). After DATA_W bits, go to DONE.
  - Any further SCLK rising edge in DONE sets an internal overrun flag and is otherwise ignored.
  - Any state → IDLE on an ncs rising edge. spi_cipo_oe drops in the same cycle.
- Commit on the ncs rising edge, registered, so outputs change on the next clk edge:
  - Write commits only when: state was DONE, no overrun, RW=1, and addr < NUM_REGS. Then register[addr] takes the data, and reg_wr_strobe[addr] pulses for exactly one clk.
  - Write to an out-of-range address: no register change, no strobe, no error.
  - Read frames never modify registers.
  - frame_err pulses for one clk if ncs rises in ADDR or DATA (short frame) or in DONE with overrun (long frame). A short or long write frame is discarded.
- Simultaneous events: an ncs edge takes priority over an SCLK edge in the same clk; that SCLK edge is ignored. A new ncs falling edge after a rising edge starts a fresh frame. The commit of the previous frame still completes, because it is registered one cycle earlier.
- Register writes take effect before any subsequent read frame. Reading a just-written register returns the new value.
- Reset mid-frame: the frame is abandoned and registers go to 0. After reset is released, the block waits in IDLE for a fresh ncs falling edge; if ncs is already low, it waits for the next falling edge.
- No X on outputs at any time after reset.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum (IDLE, ADDR, DATA, DONE);
  - the RW encoding constants SPI_RW_WRITE=1 and SPI_RW_READ=0;
  - the helper localparam FRAME_LEN.
- One natural sub-module, spi_sync_edge: a parametrised SYNC_STAGES synchroniser that outputs the synced level, a rise pulse and a fall pulse. Instantiate it three times.

Test Plan:
- Write addr 0x02 data 0xA5 (defaults) → regs_out[23:16]=0xA5 one clk after ncs rise is detected; reg_wr_strobe=5'b00100 for one clk; all other registers unchanged.
- Write 0x3C to addr 0x01, then read addr 0x01 → spi_cipo shifts out 0x3C MSB first, valid at each SCLK rising edge of the data phase; spi_cipo_oe high only between address-phase completion and ncs rise.
- Write addr 0x10 (out of range) data 0xFF → no register change, no strobe, frame_err=0; a read of addr 0x10 returns 0x00.
- Abort a write after 10 SCLKs; separately send 17 SCLKs → frame_err pulses once per frame; registers unchanged.
- Assert rst for 1 clk in the middle of the data phase of a write to addr 0x04 → all regs 0, no strobe. The next complete write of 0x80 to addr 0x04 yields regs_out[39:32]=0x80.
- Instantiate with NUM_REGS=16, DATA_W=16, ADDR_W=4 → a 21-bit write frame to addr 0xF with data 0xBEEF is committed, then read back as 0xBEEF.
